// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_chain slice: default sizes and the
// flush-mask width helper used by the chain's port list.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 2;

    // One flush bit per register stage.
    function automatic int flush_mask_width(input int depth);
        return depth;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline register slot (valid bit + payload). Update priority is
// reset > flush > stall > load > drain; reset is synchronous and active-low.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             load_i,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             drain_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
            d_d = '0;
        end else if (stall_i) begin
            v_d = v_q;
            d_d = d_q;
        end else if (load_i) begin
            v_d = load_valid_i;
            d_d = load_data_i;
        end else if (drain_i) begin
            // Payload is left in place; only the valid bit marks the slot empty.
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep chain of pipe_stage_slot registers with valid/ready on both ends.
// Define PIPE_COLLAPSE_EN for bubble-collapsing advance; default is lockstep.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                                 clk_i,
    input  logic                                 reset,
    input  logic                                 stall_i,
    input  logic [flush_mask_width(DEPTH)-1:0]   flush_i,
    input  logic                                 in_valid_i,
    input  logic [WIDTH-1:0]                     in_data_i,
    output logic                                 in_ready_o,
    output logic                                 out_valid_o,
    output logic [WIDTH-1:0]                     out_data_o,
    input  logic                                 out_ready_i
);

    // Handshake: a beat moves on a rising edge iff valid and ready are both
    // high in the cycle before it; valid never depends on ready at the same
    // port, and ready is a combinational chain back from out_ready_i.

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            load_valid;
    logic [DEPTH-1:0][WIDTH-1:0] load_data;

`ifdef PIPE_COLLAPSE_EN
    // A stage drains when it is full and its successor is empty or draining.
    always_comb begin
        adv          = '0;
        adv[DEPTH-1] = v_q[DEPTH-1] & out_ready_i & ~stall_i;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = v_q[k] & ~stall_i & (~v_q[k+1] | adv[k+1]);
        end
    end

    assign in_ready_o = reset & ~stall_i & (~v_q[0] | adv[0]);

    always_comb begin
        load          = '0;
        load_valid    = '1;
        load_data     = '0;
        load[0]       = in_valid_i & in_ready_o;
        load_data[0]  = in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
            load[k]      = adv[k-1];
            load_data[k] = d_q[k-1];
        end
    end
`else
    logic adv_all;

    // Every stage shifts together; empty slots travel down as bubbles.
    assign adv_all    = ~stall_i & (~v_q[DEPTH-1] | out_ready_i);
    assign adv        = {DEPTH{adv_all}};
    assign in_ready_o = reset & adv_all;

    always_comb begin
        load          = {DEPTH{adv_all}};
        load_valid    = '0;
        load_data     = '0;
        load_valid[0] = in_valid_i;
        load_data[0]  = in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
            load_valid[k] = v_q[k-1];
            load_data[k]  = d_q[k-1];
        end
    end
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk_i        (clk_i),
            .reset        (reset),
            .flush_i      (flush_i[k]),
            .stall_i      (stall_i),
            .load_i       (load[k]),
            .load_valid_i (load_valid[k]),
            .load_data_i  (load_data[k]),
            .drain_i      (adv[k]),
            .valid_o      (v_q[k]),
            .data_o       (d_q[k])
        );
    end

    assign out_valid_o = reset & v_q[DEPTH-1] & ~stall_i;
    assign out_data_o  = d_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=8, DEPTH=3); expectations
// follow PIPE_COLLAPSE_EN when it is defined, lockstep otherwise.
module tb_pipe_stage_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
`ifdef PIPE_COLLAPSE_EN
    localparam bit COLLAPSE = 1'b1;
`else
    localparam bit COLLAPSE = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             reset;
    logic             stall_i;
    logic [DEPTH-1:0] flush_i;
    logic             in_valid_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_ready_i;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] sb_exp;
    bit               mon_en = 1'b0;

    pipe_stage_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    // Scoreboard: input beats pushed, output beats popped and compared.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h want no output", out_data_o);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (out_data_o !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_data: got %h want %h", out_data_o, sb_exp);
                    end
                end
            end
            if (in_valid_i === 1'b1 && in_ready_o === 1'b1) exp_q.push_back(in_data_i);
        end
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i     = 1'b0;
        flush_i     = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b1;
    endtask

    task automatic push(input logic [WIDTH-1:0] val);
        in_valid_i = 1'b1;
        in_data_i  = val;
        next_cycle();
        in_valid_i = 1'b0;
    endtask

    task automatic drain(output bit ok);
        idle_inputs();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            if (exp_q.size() == 0 && out_valid_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        in_valid_i = 1'b1;
        in_data_i  = 8'h5A;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data_o); end
        reset  = 1'b1;
        mon_en = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready_o); end
        next_cycle();
        in_valid_i = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            #1;
            checks++;
            if (out_valid_o !== (e == 3)) begin
                errors++;
                $display("FAIL reset_latency_valid: edge %0d got %b want %b", e, out_valid_o, (e == 3));
            end
            next_cycle();
        end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_after_exit: got %b want 0", out_valid_o); end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = vals[i];
            #1;
            checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready: beat %0d got %b want 1", i, in_ready_o); end
            next_cycle();
        end
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== vals[i]) begin
                errors++;
                $display("FAIL stream_out: beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid_o, out_data_o, vals[i]);
            end
            next_cycle();
        end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stream_tail: got %b want 0", out_valid_o); end
    endtask

    task automatic test_back_pressure();
        idle_inputs();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(i + 1);
            #1;
            checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_accept: beat %0d got %b want 1", i, in_ready_o); end
            next_cycle();
        end
        in_data_i = 8'h04;
        repeat (2) begin
            #1;
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready_o); end
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 8'h01) begin
                errors++;
                $display("FAIL bp_head: got v=%b d=%h want v=1 d=01", out_valid_o, out_data_o);
            end
            next_cycle();
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready_o); end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 8'(i + 1)) begin
                errors++;
                $display("FAIL bp_drain: beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid_o, out_data_o, 8'(i + 1));
            end
            next_cycle();
            in_valid_i = 1'b0;
        end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_tail: got %b want 0", out_valid_o); end
    endtask

    task automatic test_ready_front_empty();
        bit ok;
        idle_inputs();
        out_ready_i = 1'b0;
        push(8'h61);
        next_cycle();
        next_cycle();
        in_valid_i = 1'b1;
        in_data_i  = 8'h62;
        #1;
        checks++; if (in_ready_o !== COLLAPSE) begin errors++; $display("FAIL front_empty_ready: got %b want %b", in_ready_o, COLLAPSE); end
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'h61) begin
            errors++;
            $display("FAIL front_empty_head: got v=%b d=%h want v=1 d=61", out_valid_o, out_data_o);
        end
        in_valid_i = 1'b0;
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL front_empty_drain: got pending=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_bubble();
        idle_inputs();
        push(8'h71);
        next_cycle();
        push(8'h72);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid_o !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL bubble_valid: cycle %0d got %b want %b", i, out_valid_o, (i % 2 == 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        out_ready_i = 1'b0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        stall_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 8'hEE;
        out_ready_i = 1'b1;
        repeat (2) begin
            #1;
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", in_ready_o); end
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b want 0", out_valid_o); end
            checks++; if (out_data_o !== 8'hA1) begin errors++; $display("FAIL stall_data: got %h want a1", out_data_o); end
            next_cycle();
        end
        stall_i    = 1'b0;
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 8'(8'hA1 + i)) begin
                errors++;
                $display("FAIL stall_resume: beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid_o, out_data_o, 8'(8'hA1 + i));
            end
            next_cycle();
        end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stall_tail: got %b want 0", out_valid_o); end
    endtask

    task automatic test_flush_middle();
        idle_inputs();
        out_ready_i = 1'b0;
        push(8'hC0);
        push(8'hB0);
        push(8'hA0);
        flush_i     = 3'b010;
        out_ready_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hC0) begin
            errors++;
            $display("FAIL flush_mid_head: got v=%b d=%h want v=1 d=c0", out_valid_o, out_data_o);
        end
        void'(exp_q.pop_back());
        next_cycle();
        flush_i = '0;
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hB0) begin
            errors++;
            $display("FAIL flush_mid_next: got v=%b d=%h want v=1 d=b0", out_valid_o, out_data_o);
        end
        repeat (3) begin
            next_cycle();
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_mid_squash: got v=%b d=%h want v=0", out_valid_o, out_data_o); end
        end
    endtask

    task automatic test_flush_all();
        idle_inputs();
        out_ready_i = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        flush_i     = 3'b111;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h77;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_all_ready: got %b want 1", in_ready_o); end
        @(negedge clk_i);
        #1;
        exp_q.delete();
        next_cycle();
        flush_i    = '0;
        in_valid_i = 1'b0;
        #1;
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL flush_all_data: got %h want 00", out_data_o); end
        repeat (4) begin
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_all_empty: got v=%b d=%h want v=0", out_valid_o, out_data_o); end
            next_cycle();
        end
    endtask

    task automatic test_reset_midstream();
        idle_inputs();
        out_ready_i = 1'b0;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        reset       = 1'b0;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h99;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", in_ready_o); end
        exp_q.delete();
        next_cycle();
        reset      = 1'b1;
        in_valid_i = 1'b0;
        #1;
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", out_data_o); end
        repeat (3) begin
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_empty: got %b want 0", out_valid_o); end
            next_cycle();
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 300; i++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            in_data_i   = 8'($urandom_range(0, 255));
            out_ready_i = ($urandom_range(0, 3) != 0);
            stall_i     = ($urandom_range(0, 7) == 0);
            next_cycle();
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL random_drain: got pending=%0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_ready_front_empty();
        test_bubble();
        test_stall();
        test_flush_middle();
        test_flush_all();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
